// File: rtl/mp_addsub_seq_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package mp_addsub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // Carry seeded into word 0: caller's cin for add, +1 of the two's complement for subtract.
  function automatic logic first_carry(input logic op, input logic cin);
    return (op == OP_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/mp_addsub_seq_addsub_word.sv
// One WIDTH-bit ripple-carry adder-subtractor word; b is inverted when op selects subtract.
module addsub_word
  import mp_addsub_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] bx;

  assign bx   = b ^ {WIDTH{~op}};
  assign c[0] = cin;

  // Full-adder cell chain, LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i + 1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/mp_addsub_seq.sv
// Word-serial multi-precision add/subtract: one WIDTH-bit word per cycle, LSW first,
// with the inter-word carry held in c_reg.
module mp_addsub_seq
  import mp_addsub_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     op,
  input  logic [WIDTH*WORDS-1:0]   a,
  input  logic [WIDTH*WORDS-1:0]   b,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH*WORDS-1:0]   sum,
  output logic                     carry
);

  localparam int unsigned N    = WIDTH * WORDS;
  localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t            state;
  logic [N-1:0]      a_r;
  logic [N-1:0]      b_r;
  logic              op_r;
  logic              c_reg;
  logic [IDXW-1:0]   idx;

  logic [WIDTH-1:0]  a_w;
  logic [WIDTH-1:0]  b_w;
  logic [WIDTH-1:0]  s_w;
  logic              c_w;
  logic              last_c;

  // Select the operand word addressed by idx.
  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int k = 0; k < int'(WORDS); k++) begin
      if (idx == IDXW'(k)) begin
        a_w = a_r[k*WIDTH +: WIDTH];
        b_w = b_r[k*WIDTH +: WIDTH];
      end
    end
  end

  assign last_c = (idx == IDXW'(WORDS - 1));

  addsub_word #(
    .WIDTH (WIDTH)
  ) u_word (
    .a    (a_w),
    .b    (b_w),
    .op   (op_r),
    .cin  (c_reg),
    .sum  (s_w),
    .cout (c_w)
  );

  // Controller, operand latches and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= OP_SUB;
      c_reg <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= op;
            idx   <= '0;
            c_reg <= first_carry(op, cin);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < int'(WORDS); k++) begin
            if (idx == IDXW'(k)) begin
              sum[k*WIDTH +: WIDTH] <= s_w;
            end
          end
          c_reg <= c_w;
          idx   <= idx + IDXW'(1);
          if (last_c) begin
            carry <= c_w;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Bench for mp_addsub_seq: 4-word and 1-word instances, vector table, hand sequences, random sweep.
module tb_mp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        start4, op4, cin4, busy4, done4, carry4;
  logic [31:0] a4, b4, sum4;
  logic        start1, op1, cin1, busy1, done1, carry1;
  logic [7:0]  a1, b1, sum1;

  mp_addsub_seq #(.WIDTH(8), .WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
  );

  mp_addsub_seq #(.WIDTH(8), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        c;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        c;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input bit sel, input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic st);
    if (sel) begin
      start1 = st; op1 = op; a1 = a[7:0]; b1 = b[7:0]; cin1 = cin;
    end else begin
      start4 = st; op4 = op; a4 = a; b4 = b; cin4 = cin;
    end
  endtask

  function automatic logic get_done(input bit sel);
    return sel ? done1 : done4;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy1 : busy4;
  endfunction
  function automatic logic get_carry(input bit sel);
    return sel ? carry1 : carry4;
  endfunction
  function automatic logic [31:0] get_sum(input bit sel);
    return sel ? {24'd0, sum1} : sum4;
  endfunction

  // Reference: add as nb+1-bit integer sum; subtract as modular difference with no-borrow flag.
  function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input int nb);
    logic [32:0] m;
    logic [32:0] t;
    exp_t        e;
    m = (33'd1 << nb) - 33'd1;
    if (op) begin
      t   = ({1'b0, a} & m) + ({1'b0, b} & m) + 33'(cin);
      e.s = 32'(t & m);
      e.c = t[nb];
    end else begin
      e.s = (a - b) & m[31:0];
      e.c = ((a & m[31:0]) >= (b & m[31:0]));
    end
    return e;
  endfunction

  // One full handshake: push expectation, pulse start, wait (bounded) for done, score it.
  task automatic run_op(input bit sel, input vec_t v);
    int   c;
    int   words;
    exp_t e;
    words = sel ? 1 : 4;
    sbq.push_back('{s: v.s, c: v.c});
    @(posedge clk); #1;
    drive(sel, v.op, v.a, v.b, v.cin, 1'b1);
    @(posedge clk); #1;
    drive(sel, v.op, v.a, v.b, v.cin, 1'b0);
    chk("busy_in_run", 64'(get_busy(sel)), 64'd1);
    c = 1;
    while (!get_done(sel) && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("done_cycle", 64'(c), 64'(words + 1));
    e = sbq.pop_front();
    if (get_done(sel)) begin
      chk("busy_in_done", 64'(get_busy(sel)), 64'd1);
      chk("sum", 64'(get_sum(sel)), 64'(e.s));
      chk("carry", 64'(get_carry(sel)), 64'(e.c));
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(get_done(sel)), 64'd0);
    chk("busy_after_done", 64'(get_busy(sel)), 64'd0);
  endtask

  vec_t tbl[7];

  initial begin
    vec_t v;
    exp_t e;
    int   c;
    bit   seen;

    tbl[0] = '{1'b1, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
    tbl[1] = '{1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    tbl[2] = '{1'b0, 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b1};
    tbl[3] = '{1'b0, 32'h00000001, 32'h00000002, 1'b0, 32'hFFFFFFFF, 1'b0};
    tbl[4] = '{1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0};
    tbl[5] = '{1'b0, 32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b1};
    tbl[6] = '{1'b1, 32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1};

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", 64'(sum4), 64'd0);
    chk("rst_carry", 64'(carry4), 64'd0);
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_done", 64'(done4), 64'd0);
    chk("rst_busy_w1", 64'(busy1), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_op(1'b0, tbl[i]);

    // start held high through RUN/DONE with different operands must not disturb the result.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'd5, 32'd3, 1'b0, 1'b1);
    sbq.push_back('{s: 32'd8, c: 1'b0});
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'hAAAAAAAA, 32'd3, 1'b0, 1'b1);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      chk("ign_busy", 64'(busy4), 64'd1);
      chk("ign_done", 64'(done4), 64'(cyc == 5));
      if (cyc == 5) begin
        e = sbq.pop_front();
        chk("ign_sum", 64'(sum4), 64'(e.s));
        chk("ign_carry", 64'(carry4), 64'(e.c));
      end
      @(posedge clk); #1;
    end
    chk("ign_idle_c6", 64'(busy4), 64'd0);
    sbq.push_back('{s: 32'hAAAAAAAD, c: 1'b0});
    @(posedge clk); #1;
    chk("ign_accept_c7", 64'(busy4), 64'd1);
    drive(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    c = 0;
    while (!done4 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    e = sbq.pop_front();
    chk("ign_second_done", 64'(done4), 64'd1);
    chk("ign_second_sum", 64'(sum4), 64'(e.s));
    @(posedge clk); #1;

    // Asynchronous reset in the second RUN cycle aborts without a done pulse.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_sum", 64'(sum4), 64'd0);
    chk("abort_carry", 64'(carry4), 64'd0);
    chk("abort_busy", 64'(busy4), 64'd0);
    chk("abort_done", 64'(done4), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done4 || busy4) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    v = '{1'b0, 32'd7, 32'd7, 1'b0, 32'd0, 1'b1};
    run_op(1'b0, v);

    // Random sweeps against the reference model, 4-word then 1-word.
    for (int i = 0; i < 1000; i++) begin
      v.op  = 1'($urandom);
      v.a   = $urandom;
      v.b   = $urandom;
      v.cin = 1'($urandom);
      e     = model(v.op, v.a, v.b, v.cin, 32);
      v.s   = e.s;
      v.c   = e.c;
      run_op(1'b0, v);
    end
    for (int i = 0; i < 1000; i++) begin
      v.op  = 1'($urandom);
      v.a   = 32'($urandom_range(0, 255));
      v.b   = 32'($urandom_range(0, 255));
      v.cin = 1'($urandom);
      e     = model(v.op, v.a, v.b, v.cin, 8);
      v.s   = e.s;
      v.c   = e.c;
      run_op(1'b1, v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
